// File: rtl/bnn_pkg.sv
// ----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the binary convolution array: command encoding,
// controller state encoding, beat/bias widths and the popcount width helper.
// Optional feature macro: BNN_CONV_BIAS_EN (adds the LOAD_BIAS state).
// ----------------------------------------------------------------------------
package bnn_pkg;

  typedef enum logic [1:0] {
    CMD_NOP      = 2'b00,
    CMD_LOAD_WGT = 2'b01,
    CMD_STREAM   = 2'b10,
    CMD_CLEAR    = 2'b11
  } cmd_e;

`ifdef BNN_CONV_BIAS_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_WGT  = 3'd1,
    ST_LOAD_BIAS = 3'd2,
    ST_STREAM    = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_WGT  = 3'd1,
    ST_STREAM    = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;
`endif

  localparam int BEAT_W = 8;
  localparam int BIAS_W = 8;

  // Bits needed to hold a popcount of 0..k*k.
  function automatic int pc_width(input int k);
    return $clog2(k * k + 1);
  endfunction

endpackage

// File: rtl/bnn_xnor_pe.sv
// ----------------------------------------------------------------------------
// bnn_xnor_pe
// One binary output-channel PE: XNOR of window against kernel, popcount of the
// matches, mapped to the signed {-1,+1} dot product 2*popcount - K*K.
// Purely combinational; the caller registers the result.
// Ports:
//   window  in  K*K  current window bits (column c at [c*K +: K])
//   kernel  in  K*K  kernel bits (row r at [r*K +: K], pairs with column r)
//   result  out OUT_W signed dot product
// ----------------------------------------------------------------------------
module bnn_xnor_pe
  import bnn_pkg::*;
#(
  parameter int K     = 7,
  parameter int OUT_W = 8
) (
  input  logic [K*K-1:0]          window,
  input  logic [K*K-1:0]          kernel,
  output logic signed [OUT_W-1:0] result
);

  localparam int PC_W = pc_width(K);

  logic [K*K-1:0]  match;
  logic [PC_W-1:0] pc;

  always_comb begin
    match = ~(window ^ kernel);
    pc    = '0;
    for (int i = 0; i < K * K; i++) begin
      pc = pc + PC_W'(match[i]);
    end
    // Modular arithmetic in OUT_W bits is exact because |result| <= K*K fits.
    result = OUT_W'({pc, 1'b0}) - OUT_W'(K * K);
  end

endmodule

// File: rtl/bnn_conv_array.sv
// ----------------------------------------------------------------------------
// bnn_conv_array
// Array of N_PE binary (XNOR/popcount) PEs sharing one K x K sliding window.
// Weights are loaded row by row; image columns are streamed in and each
// column that completes a window produces one packed result beat.
// Optional feature macro: BNN_CONV_BIAS_EN -- per-PE signed 8-bit bias with
// OUT_W saturation, loaded in a LOAD_BIAS phase after LOAD_WGT.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd[1:0], cmd_valid/rdy  command (NOP/LOAD_WGT/STREAM/CLEAR), IDLE only
//   data_in[7:0], in_valid/rdy  weight row, bias byte or image column
//   col_count[15:0]          column count, sampled when STREAM is accepted
//   out_data, out_valid/rdy  packed signed results, PE0 in LSBs
//   busy                     controller not in IDLE
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a command; CLEAR is handled here in one cycle
// LOAD_WGT  | taking N_PE*K kernel rows, PE-major
// LOAD_BIAS | taking N_PE bias bytes (BNN_CONV_BIAS_EN builds only)
// STREAM    | shifting columns into the window until col_count taken
// DRAIN     | waiting for the pipeline to empty and the last result taken
// ----------------------------------------------------------------------------
module bnn_conv_array
  import bnn_pkg::*;
#(
  parameter int N_PE  = 8,
  parameter int K     = 7,
  parameter int OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmd,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [BEAT_W-1:0]     data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           col_count,
  output logic [N_PE*OUT_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int WIN_W  = K * K;
  localparam int ROW_W  = $clog2(K);
  localparam int PE_W   = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int FILL_W = $clog2(K);

  state_e                  state_q, state_d;
  logic [WIN_W-1:0]        wgt_q [N_PE];
  logic [WIN_W-1:0]        wgt_d [N_PE];
  logic [WIN_W-1:0]        win_q, win_d, win_shift;
  logic [15:0]             col_rem_q, col_rem_d;
  logic [FILL_W-1:0]       fill_rem_q, fill_rem_d;
  logic [ROW_W-1:0]        ld_row_q, ld_row_d;
  logic [PE_W-1:0]         ld_pe_q, ld_pe_d;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [OUT_W-1:0] s1_res_q [N_PE];
  logic signed [OUT_W-1:0] s1_res_d [N_PE];
  logic                    out_valid_q, out_valid_d;
  logic [N_PE*OUT_W-1:0]   out_data_q, out_data_d;
  logic signed [OUT_W-1:0] pe_res [N_PE];

  logic cmd_acc, in_acc, out_free, stall, produce;
  logic ld_last_row, ld_last_pe;
  logic unused_data;

`ifdef BNN_CONV_BIAS_EN
  localparam int SUM_W = ((OUT_W > BIAS_W) ? OUT_W : BIAS_W) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (OUT_W - 1)));

  logic signed [BIAS_W-1:0] bias_q [N_PE];
  logic signed [BIAS_W-1:0] bias_d [N_PE];

  function automatic logic signed [OUT_W-1:0] sat_add(
    input logic signed [OUT_W-1:0]  r,
    input logic signed [BIAS_W-1:0] b
  );
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(r) + SUM_W'(b);
    if (sum > SAT_MAX)      return OUT_W'(SAT_MAX);
    else if (sum < SAT_MIN) return OUT_W'(SAT_MIN);
    else                    return OUT_W'(sum);
  endfunction
`endif

  // Newest column enters at index 0; the PEs see the post-shift window so the
  // stage-1 register captures the result in the same edge as the beat.
  assign win_shift = {win_q[WIN_W-K-1:0], data_in[K-1:0]};

  for (genvar g = 0; g < N_PE; g++) begin : g_pe
    bnn_xnor_pe #(
      .K     (K),
      .OUT_W (OUT_W)
    ) u_pe (
      .window (win_shift),
      .kernel (wgt_q[g]),
      .result (pe_res[g])
    );
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign cmd_acc     = cmd_valid & cmd_ready;
  assign out_free    = ~out_valid_q | out_ready;
  // Both stages full and the output not draining: a new result has nowhere to go.
  assign stall       = s1_valid_q & out_valid_q & ~out_ready;
  assign in_acc      = in_valid & in_ready;
  assign produce     = (state_q == ST_STREAM) & in_acc & (fill_rem_q == '0);
  assign ld_last_row = (ld_row_q == ROW_W'(K - 1));
  assign ld_last_pe  = (ld_pe_q == PE_W'(N_PE - 1));
  assign unused_data = ^data_in;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_LOAD_WGT:  in_ready = 1'b1;
`ifdef BNN_CONV_BIAS_EN
      ST_LOAD_BIAS: in_ready = 1'b1;
`endif
      ST_STREAM:    in_ready = (col_rem_q != '0) & ~stall;
      default:      in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wgt_d      = wgt_q;
    win_d      = win_q;
    col_rem_d  = col_rem_q;
    fill_rem_d = fill_rem_q;
    ld_row_d   = ld_row_q;
    ld_pe_d    = ld_pe_q;
`ifdef BNN_CONV_BIAS_EN
    bias_d     = bias_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (cmd_e'(cmd))
            CMD_LOAD_WGT: begin
              state_d  = ST_LOAD_WGT;
              ld_row_d = '0;
              ld_pe_d  = '0;
            end
            CMD_STREAM: begin
              state_d    = ST_STREAM;
              col_rem_d  = col_count;
              fill_rem_d = FILL_W'(K - 1);
            end
            CMD_CLEAR: begin
              win_d      = '0;
              fill_rem_d = FILL_W'(K - 1);
            end
            default: ;
          endcase
        end
      end
      ST_LOAD_WGT: begin
        if (in_acc) begin
          for (int p = 0; p < N_PE; p++) begin
            for (int r = 0; r < K; r++) begin
              if (PE_W'(p) == ld_pe_q && ROW_W'(r) == ld_row_q) begin
                wgt_d[p][r*K +: K] = data_in[K-1:0];
              end
            end
          end
          if (ld_last_row) begin
            ld_row_d = '0;
            if (ld_last_pe) begin
              ld_pe_d = '0;
`ifdef BNN_CONV_BIAS_EN
              state_d = ST_LOAD_BIAS;
`else
              state_d = ST_IDLE;
`endif
            end else begin
              ld_pe_d = ld_pe_q + PE_W'(1);
            end
          end else begin
            ld_row_d = ld_row_q + ROW_W'(1);
          end
        end
      end
`ifdef BNN_CONV_BIAS_EN
      ST_LOAD_BIAS: begin
        if (in_acc) begin
          for (int p = 0; p < N_PE; p++) begin
            if (PE_W'(p) == ld_pe_q) bias_d[p] = signed'(data_in);
          end
          if (ld_last_pe) begin
            ld_pe_d = '0;
            state_d = ST_IDLE;
          end else begin
            ld_pe_d = ld_pe_q + PE_W'(1);
          end
        end
      end
`endif
      ST_STREAM: begin
        if (in_acc) begin
          win_d     = win_shift;
          col_rem_d = col_rem_q - 16'd1;
          if (fill_rem_q != '0) fill_rem_d = fill_rem_q - FILL_W'(1);
        end
        if (col_rem_q == '0 || (in_acc && col_rem_q == 16'd1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid_q && out_free) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_res_d    = s1_res_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (s1_valid_q && out_free) begin
      out_valid_d = 1'b1;
      for (int p = 0; p < N_PE; p++) begin
`ifdef BNN_CONV_BIAS_EN
        out_data_d[p*OUT_W +: OUT_W] = sat_add(s1_res_q[p], bias_q[p]);
`else
        out_data_d[p*OUT_W +: OUT_W] = s1_res_q[p];
`endif
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (produce) begin
      s1_valid_d = 1'b1;
      s1_res_d   = pe_res;
    end else if (s1_valid_q && out_free) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      col_rem_q   <= '0;
      fill_rem_q  <= '0;
      ld_row_q    <= '0;
      ld_pe_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int p = 0; p < N_PE; p++) begin
        wgt_q[p]    <= '0;
        s1_res_q[p] <= '0;
`ifdef BNN_CONV_BIAS_EN
        bias_q[p]   <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      wgt_q       <= wgt_d;
      win_q       <= win_d;
      col_rem_q   <= col_rem_d;
      fill_rem_q  <= fill_rem_d;
      ld_row_q    <= ld_row_d;
      ld_pe_q     <= ld_pe_d;
      s1_valid_q  <= s1_valid_d;
      s1_res_q    <= s1_res_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef BNN_CONV_BIAS_EN
      bias_q      <= bias_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bnn_conv_array.sv
module tb_bnn_conv_array;
  import bnn_pkg::*;

  localparam int K    = 3;
  localparam int N_PE = 2;
`ifdef BNN_CONV_BIAS_EN
  localparam int OUT_W = 5;
`else
  localparam int OUT_W = 8;
`endif
  localparam int DW = N_PE * OUT_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    data_in;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   col_count;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // Reference state: kernel rows, biases and the current window (column 0 newest).
  logic [K-1:0]       mk [N_PE][K];
  logic signed [7:0]  mb [N_PE];
  logic [K-1:0]       mwin [K];

  bnn_conv_array #(.N_PE(N_PE), .K(K), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .col_count (col_count),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Signed dot product per PE over {-1,+1}, plus saturating bias when built.
  function automatic logic [DW-1:0] model_out();
    logic [DW-1:0] o;
    int m, r, lo, hi;
    o  = '0;
    hi = (1 << (OUT_W - 1)) - 1;
    lo = -(1 << (OUT_W - 1));
    for (int p = 0; p < N_PE; p++) begin
      m = 0;
      for (int c = 0; c < K; c++)
        for (int b = 0; b < K; b++)
          if (mwin[c][b] == mk[p][c][b]) m++;
      r = 2 * m - K * K;
`ifdef BNN_CONV_BIAS_EN
      r = r + int'(mb[p]);
      if (r > hi) r = hi;
      if (r < lo) r = lo;
`endif
      o[p*OUT_W +: OUT_W] = OUT_W'(r);
    end
    return o;
  endfunction

  task automatic send_cmd(input logic [1:0] c, input logic [15:0] cc);
    @(negedge clk);
    cmd = c;
    col_count = cc;
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd = 2'b00;
  endtask

  task automatic drive_beat(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    data_in = d;
    #1;
    for (int t = 0; t < 20 && !in_ready; t++) begin
      @(negedge clk);
      #1;
    end
    chk("beat_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_model_weights();
    send_cmd(CMD_LOAD_WGT, 16'd0);
    for (int p = 0; p < N_PE; p++)
      for (int r = 0; r < K; r++)
        drive_beat({5'($urandom), mk[p][r]});
`ifdef BNN_CONV_BIAS_EN
    for (int p = 0; p < N_PE; p++) drive_beat(mb[p]);
`endif
    @(negedge clk);
    chk("load_done_idle", busy, 0);
  endtask

  task automatic randomize_model();
    for (int p = 0; p < N_PE; p++) begin
      for (int r = 0; r < K; r++) mk[p][r] = K'($urandom);
      mb[p] = 8'($urandom);
    end
  endtask

  task automatic run_stream(input int n, input int stall_at, input int stall_len,
                            input bit rnd_ready, input bit zero_data,
                            output int nres, output int busy_cyc);
    logic [DW-1:0] exp_q [$];
    int fill, sent, cyc;
    send_cmd(CMD_STREAM, 16'(n));
    fill = 0; sent = 0; cyc = 0; nres = 0; busy_cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      in_valid = (sent < n);
      data_in = zero_data ? 8'h00 : 8'($urandom);
      if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
      else out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (busy) busy_cyc++;
      if (stall_len > 0 && cyc == stall_at + stall_len - 1 && sent < n)
        chk("stall_in_ready", in_ready, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else if (out_ready) begin
          chk("result", out_data, exp_q.pop_front());
          nres++;
        end
      end
      if (in_valid && in_ready) begin
        for (int c = K - 1; c > 0; c--) mwin[c] = mwin[c-1];
        mwin[0] = data_in[K-1:0];
        fill++;
        sent++;
        if (fill >= K) exp_q.push_back(model_out());
      end
      if (sent == n && exp_q.size() == 0 && !out_valid && !busy) break;
      @(posedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_beats_sent", sent, n);
    chk("stream_results_pending", exp_q.size(), 0);
    chk("stream_back_idle", busy, 0);
  endtask

  initial begin
    int nres, bc;
    logic [DW-1:0] exp_d;

    rst = 1'b1; cmd = 2'b00; cmd_valid = 1'b0; data_in = 8'hFF;
    in_valid = 1'b1; col_count = 16'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_ignores_beat", in_ready, 0);
    in_valid = 1'b0;

    // PE0 all-ones kernel, PE1 all-zeros; three all-ones columns.
    for (int r = 0; r < K; r++) begin
      mk[0][r] = '1;
      mk[1][r] = '0;
    end
    mb[0] = 8'sd127;
    mb[1] = -8'sd20;
    load_model_weights();
    send_cmd(CMD_STREAM, 16'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(8'h07);
      mwin[i] = 3'b111;
    end
    exp_d = model_out();
    @(negedge clk);
    chk("lat_one_cycle_quiet", out_valid, 0);
    @(negedge clk);
    chk("lat_two_cycle_valid", out_valid, 1);
    chk("lat_data_model", out_data, exp_d);
`ifdef BNN_CONV_BIAS_EN
    chk("lat_data_sat_const", out_data, {5'b10000, 5'b01111});
`else
    chk("lat_data_const", out_data, {8'hF7, 8'h09});
`endif
    for (int t = 0; t < 10 && busy; t++) @(negedge clk);
    chk("lat_job_done", busy, 0);

    // Random weights, 10 columns with a 5-cycle output stall mid-stream.
    randomize_model();
    load_model_weights();
    run_stream(10, 6, 5, 1'b0, 1'b0, nres, bc);
    chk("ten_col_results", nres, 8);

    run_stream(20, 0, 0, 1'b1, 1'b0, nres, bc);
    chk("random_ready_results", nres, 18);

    run_stream(2, 0, 0, 1'b0, 1'b0, nres, bc);
    chk("short_no_results", nres, 0);
    chk("short_busy_bounded", bc <= 4, 1);

    run_stream(0, 0, 0, 1'b0, 1'b0, nres, bc);
    chk("zero_no_results", nres, 0);
    chk("zero_busy_le_2", bc <= 2, 1);

    // CLEAR between jobs: fresh window fill, weights retained.
    run_stream(5, 0, 0, 1'b1, 1'b0, nres, bc);
    chk("pre_clear_results", nres, 3);
    send_cmd(CMD_CLEAR, 16'd0);
    @(negedge clk);
    chk("clear_one_cycle", busy, 0);
    run_stream(4, 0, 0, 1'b1, 1'b0, nres, bc);
    chk("post_clear_results", nres, 2);

    // Reset after 4 of 10 beats.
    send_cmd(CMD_STREAM, 16'd10);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(8'($urandom));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", out_valid, 0);
    end
    for (int p = 0; p < N_PE; p++) begin
      for (int r = 0; r < K; r++) mk[p][r] = '0;
      mb[p] = '0;
    end
    run_stream(3, 0, 0, 1'b0, 1'b1, nres, bc);
    chk("abort_zero_weights_results", nres, 1);
    for (int c = 0; c < K; c++) mwin[c] = '0;
    chk("abort_zero_model_plus_kk", model_out(), {OUT_W'(9), OUT_W'(9)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
